// File: rtl/mux_sel_scheduler_if.sv
// mux_sel_scheduler_if: request/control inputs and select outputs exchanged between
// the board I/O side (master) and the select scheduler (slave).
interface mux_sel_scheduler_if;
    logic [3:0] req;
    logic       mode;
    logic       step_key;
    logic [1:0] sel;
    logic       sel_valid;
    logic       tick;

    modport master (
        output req,
        output mode,
        output step_key,
        input  sel,
        input  sel_valid,
        input  tick
    );

    modport slave (
        input  req,
        input  mode,
        input  step_key,
        output sel,
        output sel_valid,
        output tick
    );
endinterface

// File: rtl/mux_sel_scheduler.sv
// mux_sel_scheduler: round-robin scheduler driving the 2-bit select of the 4:1 switch-to-LED mux.
// Define DEBOUNCE_EN to build the step-key debouncer (DB_CYCLES stable clocks per accepted level).
module mux_sel_scheduler #(
    parameter int DWELL_CYCLES = 12_000_000,
    parameter int DB_CYCLES    = 240_000
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_scheduler_if.slave bus
);
    localparam int               CNT_W    = $clog2(DWELL_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             sel_valid_q, sel_valid_d;
    logic             tick_q, tick_d;

    logic [3:0]       req_meta_q, rq_q;
    logic             mode_meta_q, md_q;
    logic             key_meta_q, key_s_q;
    logic             key_prev_q;

    logic             key_lvl_s;
    logic             step_ev_s;
    logic             advance_s;
    logic [1:0]       pick_s;

    if (DWELL_CYCLES < 2 || DB_CYCLES < 1) begin : g_bad_cfg
        $error("mux_sel_scheduler: DWELL_CYCLES must be >= 2 and DB_CYCLES >= 1");
    end

    // First asserted request after cur, wrapping, with cur itself checked last.
    function automatic logic [1:0] rr_pick(input logic [1:0] cur, input logic [3:0] r);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = cur;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = cur + 2'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Synchronizers clear to 0, so a key held through reset already reads as pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_meta_q  <= 4'b0000;
            rq_q        <= 4'b0000;
            mode_meta_q <= 1'b0;
            md_q        <= 1'b0;
            key_meta_q  <= 1'b0;
            key_s_q     <= 1'b0;
        end else begin
            req_meta_q  <= bus.req;
            rq_q        <= req_meta_q;
            mode_meta_q <= bus.mode;
            md_q        <= mode_meta_q;
            key_meta_q  <= bus.step_key;
            key_s_q     <= key_meta_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int              DB_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            key_acc_q, key_acc_d;

    // Accept a new key level only after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_cnt_d  = db_cnt_q;
        key_acc_d = key_acc_q;
        if (key_s_q == key_acc_q) begin
            db_cnt_d  = {DB_W{1'b0}};
            key_acc_d = key_acc_q;
        end else if (db_cnt_q == DB_LAST) begin
            db_cnt_d  = {DB_W{1'b0}};
            key_acc_d = key_s_q;
        end else begin
            db_cnt_d  = db_cnt_q + DB_W'(1);
            key_acc_d = key_acc_q;
        end
    end

    // Debounce state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt_q  <= {DB_W{1'b0}};
            key_acc_q <= 1'b0;
        end else begin
            db_cnt_q  <= db_cnt_d;
            key_acc_q <= key_acc_d;
        end
    end

    assign key_lvl_s = key_acc_q;
`else
    assign key_lvl_s = key_s_q;
`endif

    // Key is active-low: a press is a 1 -> 0 transition of the accepted level.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_prev_q <= 1'b0;
        end else begin
            key_prev_q <= key_lvl_s;
        end
    end

    assign step_ev_s = key_prev_q & ~key_lvl_s;
    assign pick_s    = rr_pick(sel_q, rq_q);

    // Next state: any mix of terminal count, step event and grant loss folds into one advance.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        sel_valid_d = sel_valid_q;
        tick_d      = 1'b0;
        advance_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = {CNT_W{1'b0}};
                if (rq_q != 4'b0000) begin
                    advance_s   = 1'b1;
                    state_d     = ST_GRANT;
                    sel_valid_d = 1'b1;
                end else begin
                    sel_valid_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rq_q == 4'b0000) begin
                    state_d     = ST_IDLE;
                    sel_valid_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                end else if (!rq_q[sel_q] || step_ev_s || (!md_q && (cnt_q == CNT_LAST))) begin
                    advance_s   = 1'b1;
                    sel_valid_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                end else if (md_q) begin
                    sel_valid_d = 1'b1;
                    cnt_d       = {CNT_W{1'b0}};
                end else begin
                    sel_valid_d = 1'b1;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sel_valid_d = 1'b0;
                cnt_d       = {CNT_W{1'b0}};
            end
        endcase
        if (advance_s) begin
            sel_d  = pick_s;
            tick_d = (pick_s != sel_q);
        end else begin
            sel_d  = sel_q;
            tick_d = 1'b0;
        end
    end

    // FSM, dwell counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            sel_q       <= 2'd0;
            sel_valid_q <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            sel_valid_q <= sel_valid_d;
            tick_q      <= tick_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.tick      = tick_q;
endmodule
